// File: rtl/cortex_m0_exc_entry.sv
// Cortex-M0 exception entry sequencer: accepts an NVIC request, pushes the
// 8-word stack frame, fetches the vector and hands PC/SP/LR/IPSR to the core.
module cortex_m0_exc_entry #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
  parameter int          EXC_NUM_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exc_req,
  input  logic [EXC_NUM_W-1:0] exc_num,
  output logic                 exc_ack,
  input  logic [31:0]          cur_sp,
  input  logic [31:0]          ret_pc,
  input  logic [31:0]          xpsr_in,
  input  logic                 in_handler,
  input  logic                 spsel,
  output logic [3:0]           rf_raddr,
  input  logic [31:0]          rf_rdata,
  output logic                 bus_req,
  output logic                 bus_write,
  output logic [31:0]          bus_addr,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_ready,
  input  logic                 bus_err,
  input  logic [31:0]          bus_rdata,
  output logic                 entry_busy,
  output logic                 entry_done,
  output logic [31:0]          new_pc,
  output logic [31:0]          new_sp,
  output logic [31:0]          new_lr,
  output logic [EXC_NUM_W-1:0] new_ipsr,
  output logic                 lockup
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_VECTOR,
    S_DONE,
    S_LOCKUP
  } state_t;

  state_t               state_reg, state_next;
  logic [2:0]           idx_reg;
  logic [EXC_NUM_W-1:0] num_reg;
  logic [31:0]          pc_reg;
  logic [31:0]          xpsr_reg;
  logic [31:0]          frame_reg;
  logic [31:0]          exc_ret_reg;

  logic        accept;
  logic [31:0] aligned_sp;
  logic [31:0] frame_calc;
  logic [31:0] xpsr_stk;
  logic [31:0] exc_ret_calc;
  logic [31:0] vec_addr;
  logic        vec_ok;

  assign accept     = (state_reg == S_IDLE) && exc_req;
  // Frame must be 8-byte aligned; xPSR bit9 records whether padding was inserted.
  assign aligned_sp = cur_sp[2] ? (cur_sp - 32'd4) : cur_sp;
  assign frame_calc = aligned_sp - 32'd32;
  assign xpsr_stk   = {xpsr_in[31:10], cur_sp[2], xpsr_in[8:0]};
  assign exc_ret_calc = in_handler ? 32'hFFFF_FFF1 :
                        spsel      ? 32'hFFFF_FFFD : 32'hFFFF_FFF9;
  assign vec_addr   = VECTOR_BASE + {{(30-EXC_NUM_W){1'b0}}, num_reg, 2'b00};
  assign vec_ok     = bus_ready && !bus_err && bus_rdata[0];

  always_comb begin
    state_next = state_reg;
    exc_ack    = 1'b0;
    bus_req    = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = 32'd0;
    bus_wdata  = 32'd0;
    rf_raddr   = 4'd0;
    entry_busy = 1'b0;
    entry_done = 1'b0;
    lockup     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (exc_req) begin
          exc_ack    = 1'b1;
          state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        entry_busy = 1'b1;
        bus_req    = 1'b1;
        bus_write  = 1'b1;
        bus_addr   = frame_reg + {27'd0, idx_reg, 2'b00};
        case (idx_reg)
          3'd4:    rf_raddr = 4'd12;
          3'd5:    rf_raddr = 4'd14;
          default: rf_raddr = {1'b0, idx_reg};
        endcase
        case (idx_reg)
          3'd6:    bus_wdata = pc_reg;
          3'd7:    bus_wdata = xpsr_reg;
          default: bus_wdata = rf_rdata;
        endcase
        if (bus_ready) begin
          if (bus_err)
            state_next = S_LOCKUP;
          else if (idx_reg == 3'd7)
            state_next = S_VECTOR;
        end
      end
      S_VECTOR: begin
        entry_busy = 1'b1;
        bus_req    = 1'b1;
        bus_addr   = vec_addr;
        if (bus_ready)
          state_next = vec_ok ? S_DONE : S_LOCKUP;
      end
      S_DONE: begin
        entry_busy = 1'b1;
        entry_done = 1'b1;
        state_next = S_IDLE;
      end
      S_LOCKUP: begin
        lockup = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      idx_reg     <= 3'd0;
      num_reg     <= '0;
      pc_reg      <= 32'd0;
      xpsr_reg    <= 32'd0;
      frame_reg   <= 32'd0;
      exc_ret_reg <= 32'd0;
      new_pc      <= 32'd0;
      new_sp      <= 32'd0;
      new_lr      <= 32'd0;
      new_ipsr    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        idx_reg     <= 3'd0;
        num_reg     <= exc_num;
        pc_reg      <= ret_pc;
        xpsr_reg    <= xpsr_stk;
        frame_reg   <= frame_calc;
        exc_ret_reg <= exc_ret_calc;
      end
      // idx wraps to 0 after the eighth word, ready for the next entry
      if (state_reg == S_PUSH && bus_ready && !bus_err)
        idx_reg <= idx_reg + 3'd1;
      if (state_reg == S_VECTOR && vec_ok) begin
        new_pc   <= {bus_rdata[31:1], 1'b0};
        new_sp   <= frame_reg;
        new_lr   <= exc_ret_reg;
        new_ipsr <= num_reg;
      end
    end
  end

endmodule

// File: tb/tb_cortex_m0_exc_entry.sv
// Directed bench for cortex_m0_exc_entry: bus slave with wait states and
// error injection, frame/vector logging and hand-computed expectations.
module tb_cortex_m0_exc_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_req = 1'b0;
  logic [5:0]  exc_num = 6'd0;
  logic        exc_ack;
  logic [31:0] cur_sp = 32'd0;
  logic [31:0] ret_pc = 32'd0;
  logic [31:0] xpsr_in = 32'd0;
  logic        in_handler = 1'b0;
  logic        spsel = 1'b0;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        entry_busy;
  logic        entry_done;
  logic [31:0] new_pc;
  logic [31:0] new_sp;
  logic [31:0] new_lr;
  logic [5:0]  new_ipsr;
  logic        lockup;

  cortex_m0_exc_entry #(.VECTOR_BASE(32'h0000_0000), .EXC_NUM_W(6)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_num(exc_num),
    .exc_ack(exc_ack), .cur_sp(cur_sp), .ret_pc(ret_pc), .xpsr_in(xpsr_in),
    .in_handler(in_handler), .spsel(spsel), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .bus_req(bus_req), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_err(bus_err), .bus_rdata(bus_rdata), .entry_busy(entry_busy),
    .entry_done(entry_done), .new_pc(new_pc), .new_sp(new_sp),
    .new_lr(new_lr), .new_ipsr(new_ipsr), .lockup(lockup)
  );

  always #5 clk = ~clk;

  // register file: each register reads back a tag of its own number
  assign rf_rdata = 32'hC0DE_0000 | {28'd0, rf_raddr};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave / monitor state
  int          waits = 0;
  int          err_at = -1;
  logic [31:0] vec_data = 32'h0000_0101;
  int          wcnt = 0;
  int          xfer = 0;
  int          bus_cycles = 0;
  int          ack_cnt = 0;
  int          stab_err = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_wdata = 32'd0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  logic [31:0] rd_addr = 32'd0;

  always @(negedge clk) begin
    if (exc_ack) ack_cnt++;
    if (bus_req) begin
      bus_cycles++;
      if (prev_wait && (bus_addr !== prev_addr || bus_wdata !== prev_wdata))
        stab_err++;
      prev_addr  = bus_addr;
      prev_wdata = bus_wdata;
      if (wcnt >= waits) begin
        bus_ready = 1'b1;
        bus_err   = (xfer == err_at);
        bus_rdata = bus_write ? 32'hDEAD_BEEF : vec_data;
        if (bus_write && xfer < 8) begin
          wr_addr[xfer] = bus_addr;
          wr_data[xfer] = bus_wdata;
        end
        if (!bus_write) rd_addr = bus_addr;
        xfer++;
        wcnt = 0;
        prev_wait = 1'b0;
      end else begin
        bus_ready = 1'b0;
        bus_err   = 1'b0;
        wcnt++;
        prev_wait = 1'b1;
      end
    end else begin
      bus_ready = 1'b0;
      bus_err   = 1'b0;
      wcnt = 0;
      prev_wait = 1'b0;
    end
  end

  task automatic clear_logs();
    xfer = 0; bus_cycles = 0; ack_cnt = 0; stab_err = 0;
    for (int i = 0; i < 8; i++) begin
      wr_addr[i] = 32'hX;
      wr_data[i] = 32'hX;
    end
    rd_addr = 32'd0;
  endtask

  task automatic start_entry(input logic [31:0] sp, input logic [5:0] num,
                             input logic inh, input logic sps);
    clear_logs();
    @(posedge clk); #1;
    cur_sp = sp; exc_num = num; in_handler = inh; spsel = sps;
    exc_req = 1'b1;
    @(posedge clk); #1;
    exc_req = 1'b0;
    exc_num = 6'd63;  // changes after ack must be ignored
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(entry_done || lockup) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] frame,
                             input logic [31:0] xpsr_exp);
    logic [31:0] exp_d [0:7];
    exp_d[0] = 32'hC0DE_0000; exp_d[1] = 32'hC0DE_0001;
    exp_d[2] = 32'hC0DE_0002; exp_d[3] = 32'hC0DE_0003;
    exp_d[4] = 32'hC0DE_000C; exp_d[5] = 32'hC0DE_000E;
    exp_d[6] = 32'h0000_0222; exp_d[7] = xpsr_exp;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_waddr%0d", tag, i), wr_addr[i], frame + 32'(4 * i));
      check_eq($sformatf("%s_wdata%0d", tag, i), wr_data[i], exp_d[i]);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] pc,
                              input logic [31:0] sp, input logic [31:0] lr,
                              input logic [5:0] ipsr, input logic [31:0] vaddr);
    check_eq({tag, "_done"}, {31'd0, entry_done}, 32'd1);
    check_eq({tag, "_pc"}, new_pc, pc);
    check_eq({tag, "_sp"}, new_sp, sp);
    check_eq({tag, "_lr"}, new_lr, lr);
    check_eq({tag, "_ipsr"}, {26'd0, new_ipsr}, {26'd0, ipsr});
    check_eq({tag, "_vaddr"}, rd_addr, vaddr);
    check_eq({tag, "_acks"}, ack_cnt, 32'd1);
    @(negedge clk); #1;
    check_eq({tag, "_done_pulse"}, {31'd0, entry_done}, 32'd0);
    check_eq({tag, "_idle_busy"}, {31'd0, entry_busy}, 32'd0);
    $display("entry %s: pc=%h sp=%h lr=%h ipsr=%0d bus_cycles=%0d",
             tag, new_pc, new_sp, new_lr, new_ipsr, bus_cycles);
  endtask

  initial begin
    ret_pc = 32'h0000_0222;
    xpsr_in = 32'h2100_0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, entry_busy}, 32'd0);
    check_eq("rst_lockup", {31'd0, lockup}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_new_pc", new_pc, 32'd0);
    reset = 1'b1;

    // aligned SP, thread/MSP
    waits = 0; vec_data = 32'h0000_0101;
    start_entry(32'h2000_1000, 6'd16, 1'b0, 1'b0);
    wait_end("t1");
    check_frame("t1", 32'h2000_0FE0, 32'h2100_0000);
    check_eq("t1_bus_cycles", bus_cycles, 32'd9);
    check_result("t1", 32'h0000_0100, 32'h2000_0FE0, 32'hFFFF_FFF9, 6'd16, 32'h0000_0040);

    // unaligned SP, thread/PSP
    vec_data = 32'h0000_0201;
    start_entry(32'h2000_1004, 6'd3, 1'b0, 1'b1);
    wait_end("t2");
    check_frame("t2", 32'h2000_0FE0, 32'h2100_0200);
    check_result("t2", 32'h0000_0200, 32'h2000_0FE0, 32'hFFFF_FFFD, 6'd3, 32'h0000_000C);

    // handler mode, two wait states per transfer
    waits = 2; vec_data = 32'h0000_0301;
    start_entry(32'h2000_0800, 6'd2, 1'b1, 1'b1);
    wait_end("t3");
    check_frame("t3", 32'h2000_07E0, 32'h2100_0000);
    check_eq("t3_bus_cycles", bus_cycles, 32'd27);
    check_eq("t3_stable", stab_err, 32'd0);
    check_result("t3", 32'h0000_0300, 32'h2000_07E0, 32'hFFFF_FFF1, 6'd2, 32'h0000_0008);

    // SP below the frame size wraps modulo 2^32
    waits = 0; vec_data = 32'h0000_0401;
    start_entry(32'h0000_0010, 6'd17, 1'b0, 1'b0);
    wait_end("t4");
    check_eq("t4_waddr0", wr_addr[0], 32'hFFFF_FFF0);
    check_result("t4", 32'h0000_0400, 32'hFFFF_FFF0, 32'hFFFF_FFF9, 6'd17, 32'h0000_0044);

    // async reset mid-push, then restart from idx 0
    waits = 2;
    start_entry(32'h2000_1000, 6'd16, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("t5_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("t5_rst_busy", {31'd0, entry_busy}, 32'd0);
    check_eq("t5_rst_new_pc", new_pc, 32'd0);
    check_eq("t5_rst_new_sp", new_sp, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    waits = 0; vec_data = 32'h0000_0101;
    start_entry(32'h2000_1000, 6'd16, 1'b0, 1'b0);
    wait_end("t5");
    check_frame("t5", 32'h2000_0FE0, 32'h2100_0000);
    check_result("t5", 32'h0000_0100, 32'h2000_0FE0, 32'hFFFF_FFF9, 6'd16, 32'h0000_0040);

    // bus error on third push write -> lockup, no further acks
    err_at = 2;
    start_entry(32'h2000_1000, 6'd16, 1'b0, 1'b0);
    wait_end("t6");
    check_eq("t6_lockup", {31'd0, lockup}, 32'd1);
    check_eq("t6_xfers", xfer, 32'd3);
    err_at = -1;
    bus_cycles = 0; ack_cnt = 0;
    exc_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    exc_req = 1'b0;
    check_eq("t6_no_bus", bus_cycles, 32'd0);
    check_eq("t6_no_ack", ack_cnt, 32'd0);
    check_eq("t6_lockup_sticky", {31'd0, lockup}, 32'd1);
    check_eq("t6_busy", {31'd0, entry_busy}, 32'd0);
    $display("entry t6: lockup=%0d after %0d transfers", lockup, xfer);

    // vector with bit0 clear -> lockup, outputs not updated
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    vec_data = 32'h0000_1000;
    start_entry(32'h2000_1000, 6'd16, 1'b0, 1'b0);
    wait_end("t7");
    check_eq("t7_lockup", {31'd0, lockup}, 32'd1);
    check_eq("t7_new_pc", new_pc, 32'd0);
    check_eq("t7_xfers", xfer, 32'd9);
    $display("entry t7: lockup=%0d after %0d transfers", lockup, xfer);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
